// File: rtl/debounce_pkg.sv
// Shared constants and helpers for the multi-channel button debouncer.
package debounce_pkg;

    // 10 ms of stability at a 100 MHz system clock.
    localparam int STABLE_CYCLES_10MS_100MHZ = 1_000_000;

    // Short stability window so simulations finish quickly.
    localparam int STABLE_CYCLES_SIM = 4;

    // Counter width for a given stability window; never narrower than one bit.
    function automatic int cnt_width(input int stable_cycles);
        int w;
        w = $clog2(stable_cycles);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/debounce_chan.sv
// One debouncer channel: two-flop synchroniser, stability counter, accepted
// level and optional rise/fall strobes.
// Optional feature macro: DEBOUNCE_EDGE_PULSE_EN (builds the strobe registers;
// when undefined rise/fall are tied low).
module debounce_chan
    import debounce_pkg::*;
#(
    parameter int   STABLE_CYCLES = STABLE_CYCLES_SIM,
    parameter logic RST_VAL       = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic level,
    output logic rise,
    output logic fall
);

    localparam int              CNT_W   = cnt_width(STABLE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES - 1);

    logic             sync1_reg;
    logic             sync0_reg;
    logic [CNT_W-1:0] cnt_reg;
    logic             level_reg;
    logic             accept;

    // The synchronised sample differs from the accepted level and has done so
    // for the full window: the new level is taken on this edge.
    assign accept = (sync0_reg != level_reg) && (cnt_reg == CNT_MAX);

    // Two-flop synchroniser for the asynchronous pin.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_reg <= RST_VAL;
            sync0_reg <= RST_VAL;
        end else begin
            sync1_reg <= din;
            sync0_reg <= sync1_reg;
        end
    end

    // Stability counter: restarts whenever the sample matches the accepted
    // level, and clears when a new level is accepted, so it never wraps.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_reg   <= '0;
            level_reg <= RST_VAL;
        end else if (sync0_reg == level_reg) begin
            cnt_reg <= '0;
        end else if (cnt_reg == CNT_MAX) begin
            level_reg <= sync0_reg;
            cnt_reg   <= '0;
        end else begin
            cnt_reg <= cnt_reg + 1'b1;
        end
    end

    assign level = level_reg;

`ifdef DEBOUNCE_EDGE_PULSE_EN
    logic rise_reg;
    logic fall_reg;

    // Registered strobes, high only on the cycle after a level is accepted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rise_reg <= 1'b0;
            fall_reg <= 1'b0;
        end else begin
            rise_reg <= accept &  sync0_reg;
            fall_reg <= accept & ~sync0_reg;
        end
    end

    assign rise = rise_reg;
    assign fall = fall_reg;
`else
    assign rise = 1'b0;
    assign fall = 1'b0;
`endif

endmodule

// File: rtl/btn_debounce_multi.sv
// Multi-channel debouncer for push-buttons and slide switches. Every channel
// is an independent debounce_chan instance.
// Optional feature macro: DEBOUNCE_EDGE_PULSE_EN (enables btn_rise/btn_fall;
// when undefined those ports stay present but are driven low).
module btn_debounce_multi
    import debounce_pkg::*;
#(
    parameter int   CHANNELS      = 5,
    parameter int   STABLE_CYCLES = STABLE_CYCLES_10MS_100MHZ,
    parameter logic RST_VAL       = 1'b0
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [CHANNELS-1:0] btn_in,
    output logic [CHANNELS-1:0] btn_out,
    output logic [CHANNELS-1:0] btn_rise,
    output logic [CHANNELS-1:0] btn_fall
);

    generate
        for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_chan
            debounce_chan #(
                .STABLE_CYCLES(STABLE_CYCLES),
                .RST_VAL      (RST_VAL)
            ) u_chan (
                .clk  (clk),
                .rst_n(rst_n),
                .din  (btn_in[gi]),
                .level(btn_out[gi]),
                .rise (btn_rise[gi]),
                .fall (btn_fall[gi])
            );
        end
    endgenerate

endmodule

// File: tb/tb_btn_debounce_multi.sv
// Self-checking bench for btn_debounce_multi (4 channels, 4-cycle window).
// The reference model states the acceptance rule directly: a channel takes a
// new level when its last STABLE_CYCLES synchronised samples (the pin value
// two edges earlier) all differ from the accepted level.
module tb_btn_debounce_multi;

    localparam int CH = 4;
    localparam int SC = 4;
`ifdef DEBOUNCE_EDGE_PULSE_EN
    localparam bit EDGE_EN = 1'b1;
`else
    localparam bit EDGE_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [CH-1:0] btn_in = '0;
    logic [CH-1:0] btn_out;
    logic [CH-1:0] btn_rise;
    logic [CH-1:0] btn_fall;

    int n_checks = 0;
    int n_fail   = 0;

    btn_debounce_multi #(
        .CHANNELS     (CH),
        .STABLE_CYCLES(SC),
        .RST_VAL      (1'b0)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .btn_in  (btn_in),
        .btn_out (btn_out),
        .btn_rise(btn_rise),
        .btn_fall(btn_fall)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    // hist[j] = pin value captured at the (j+1)-th most recent edge.
    logic [CH-1:0] hist [0:SC];
    logic [CH-1:0] m_out;
    logic [CH-1:0] m_rise;
    logic [CH-1:0] m_fall;
    logic [CH-1:0] acc;

    // Channel accepts when the window of SC synchronised samples all differ.
    always_comb begin
        acc = '0;
        for (int c = 0; c < CH; c++) begin
            logic all_diff;
            all_diff = 1'b1;
            for (int j = 1; j <= SC; j++)
                if (hist[j][c] == m_out[c]) all_diff = 1'b0;
            acc[c] = all_diff;
        end
    end

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int j = 0; j <= SC; j++) hist[j] <= '0;
            m_out  <= '0;
            m_rise <= '0;
            m_fall <= '0;
        end else begin
            hist[0] <= btn_in;
            for (int j = 1; j <= SC; j++) hist[j] <= hist[j-1];
            m_out  <= m_out ^ acc;
            m_rise <= EDGE_EN ? (acc & ~m_out) : '0;
            m_fall <= EDGE_EN ? (acc &  m_out) : '0;
        end
    end

    task automatic chk(input string name, input logic [CH-1:0] act, input logic [CH-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Every-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        chk("model_out",  btn_out,  m_out);
        chk("model_rise", btn_rise, m_rise);
        chk("model_fall", btn_fall, m_fall);
    end

    task automatic wait_edges(input int n);
        repeat (n) @(negedge clk);
    endtask

    // ---------------- directed stimulus ----------------
    initial begin
        logic [CH-1:0] all_rise;
        all_rise = EDGE_EN ? 4'hF : 4'h0;

        // Reset with all pins high.
        rst_n  = 1'b0;
        btn_in = 4'hF;
        wait_edges(3);
        chk("rst_out", btn_out, 4'h0);
        chk("rst_rise", btn_rise, 4'h0);
        chk("rst_fall", btn_fall, 4'h0);
        rst_n = 1'b1;
        wait_edges(5);
        chk("rst_rel_edge5_out", btn_out, 4'h0);
        wait_edges(1);
        chk("rst_rel_edge6_out", btn_out, 4'hF);
        chk("rst_rel_edge6_rise", btn_rise, all_rise);
        wait_edges(1);
        chk("rst_rel_edge7_rise", btn_rise, 4'h0);
        $display("txn reset: all pins high accepted at edge 6 after release");

        btn_in = 4'h0;
        wait_edges(6);
        chk("all_fall_out", btn_out, 4'h0);
        chk("all_fall_strobe", btn_fall, all_rise);
        wait_edges(3);
        $display("txn release-all: all channels fall at edge 6");

        // Clean press and release on channel 0.
        btn_in = 4'h1;
        wait_edges(5);
        chk("press_edge5_out", btn_out, 4'h0);
        wait_edges(1);
        chk("press_edge6_out", btn_out, 4'h1);
        chk("press_edge6_rise", btn_rise, all_rise & 4'h1);
        wait_edges(1);
        chk("press_edge7_rise", btn_rise, 4'h0);
        wait_edges(3);
        btn_in = 4'h0;
        wait_edges(5);
        chk("release_edge5_out", btn_out, 4'h1);
        wait_edges(1);
        chk("release_edge6_out", btn_out, 4'h0);
        chk("release_edge6_fall", btn_fall, all_rise & 4'h1);
        wait_edges(3);
        $display("txn clean press ch0: rise at edge 6, fall 6 edges after release");

        // Glitches on channel 1: too short to be accepted.
        btn_in = 4'h2; wait_edges(3);
        btn_in = 4'h0; wait_edges(10);
        chk("glitch3_out", btn_out, 4'h0);
        btn_in = 4'h2; wait_edges(3);
        btn_in = 4'h0; wait_edges(1);
        btn_in = 4'h2; wait_edges(3);
        btn_in = 4'h0; wait_edges(10);
        chk("glitch_3_1_3_out", btn_out, 4'h0);
        $display("txn glitch ch1: pulses of 3 cycles rejected");

        // Boundary on channel 2: exactly SC samples high is accepted.
        btn_in = 4'h4; wait_edges(4);
        btn_in = 4'h0; wait_edges(2);
        chk("boundary_accept_out", btn_out, 4'h4);
        wait_edges(3);
        chk("boundary_hold_out", btn_out, 4'h4);
        wait_edges(1);
        chk("boundary_fall_out", btn_out, 4'h0);
        chk("boundary_fall_strobe", btn_fall, all_rise & 4'h4);
        wait_edges(3);
        $display("txn boundary ch2: 4-cycle pulse accepted, fall 6 edges after release");

        // Mid-count reset on channel 3.
        btn_in = 4'h8; wait_edges(4);
        rst_n = 1'b0; wait_edges(2);
        chk("midrst_out", btn_out, 4'h0);
        chk("midrst_rise", btn_rise, 4'h0);
        rst_n = 1'b1;
        wait_edges(5);
        chk("midrst_edge5_out", btn_out, 4'h0);
        wait_edges(1);
        chk("midrst_edge6_out", btn_out, 4'h8);
        chk("midrst_edge6_rise", btn_rise, all_rise & 4'h8);
        btn_in = 4'h0;
        wait_edges(8);
        $display("txn mid-count reset ch3: count restarted, rise 6 edges after release");

        // Slow random activity, checked only by the model.
        for (int i = 0; i < 300; i++) begin
            for (int c = 0; c < CH; c++)
                if ($urandom_range(0, 5) == 0) btn_in[c] = ~btn_in[c];
            wait_edges(1);
        end
        $display("txn random: 300 cycles of slow toggling compared against model");

        wait_edges(2);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/btn_debounce_multi.md
# btn_debounce_multi

Parametrised multi-channel debouncer for push-buttons and slide switches, replacing the fixed three-flop delay chain used at the board inputs. Each channel synchronises its raw input through two flops, then asserts a new level only after that level has held for a programmable number of consecutive clocks. Optional single-cycle rise/fall strobes drive the FSM and counter logic downstream. It sits between the top-level pin inputs and all user-logic consumers.

## Interface
Parameters:
- CHANNELS, 5: number of independent input channels, ≥1.
- STABLE_CYCLES, 1_000_000: consecutive stable synchronised samples required to accept a new level (10 ms at 100 MHz), ≥2.
- RST_VAL, 1'b0: reset value of every `btn_out` bit (released button).

Ports:
- clk  input  1  system clock; all state on rising edge.
- rst_n  input  1  asynchronous, active-low reset; one clock domain, reset asserted asynchronously.
- btn_in  input  CHANNELS  raw, asynchronous pin levels.
- btn_out  output  CHANNELS  debounced level per channel.
- btn_rise  output  CHANNELS  one-cycle strobe when `btn_out[i]` goes 0→1.
- btn_fall  output  CHANNELS  one-cycle strobe when `btn_out[i]` goes 1→0.

## Operation
- Per channel: sync1 <= btn_in[i]; sync0 <= sync1. Call sync0 `s`.
- Counter `cnt`, width CNT_W = $clog2(STABLE_CYCLES).
- Each clock:
  - If s == btn_out[i], then cnt <= 0. Any glitch back to the accepted level restarts the count.
  - Else, if cnt == STABLE_CYCLES-1, then btn_out[i] <= s, cnt <= 0, and the matching rise/fall strobe is 1 for the next cycle.
  - Else, cnt <= cnt + 1.
- Counter never wraps: its maximum value is STABLE_CYCLES-1, after which it clears.
- Channels are fully independent. Simultaneous acceptance on several channels in the same cycle is legal and produces simultaneous strobes.
- Strobes are registered. They are high for exactly one cycle and are never high while `btn_out` is unchanged.
- btn_rise[i] and btn_fall[i] are never both high.

## Timing
- Reset (rst_n low, asynchronous):
  - sync flops = RST_VAL
  - btn_out = RST_VAL on all bits
  - cnt = 0
  - btn_rise = btn_fall = 0
- Reset mid-count discards the partial count. No strobe is issued on entry to or exit from reset.
- After reset release, an input already at ~RST_VAL is accepted after normal latency and produces one strobe.
- Latency: input changes and stays stable. Count the first rising edge that captures it as edge 1. btn_out and the strobe update at edge STABLE_CYCLES+2.
- Rejection: any pulse shorter than STABLE_CYCLES synchronised cycles produces no output change.
- Toggling faster than STABLE_CYCLES cycles holds btn_out indefinitely.

## Configuration
- Macro `DEBOUNCE_EDGE_PULSE_EN`.
- Defined: btn_rise/btn_fall are generated as above.
- Undefined: the strobe registers are not built. btn_rise and btn_fall are tied to 0. Ports remain present so the top level is unchanged; btn_out behaviour is identical.

## Structure
- Package `debounce_pkg`:
  - default STABLE_CYCLES constants for 100 MHz (10 ms) and for simulation (4)
  - function computing CNT_W
- Sub-module `debounce_chan`: one channel, containing the synchronizer, counter, level and strobes. The top instantiates it CHANNELS times in a generate loop.
- Target size: about 150 lines.

## Test plan
All scenarios use CHANNELS=4, STABLE_CYCLES=4, RST_VAL=0, macro defined.
- Reset: assert rst_n=0 with btn_in=4'hF, then release → btn_out=0 and strobes 0 during reset. btn_out=4'hF at edge 6 after release with btn_rise=4'hF for exactly one cycle.
- Clean press: btn_in[0] 0→1 and held → btn_out[0] rises at edge 6, btn_rise[0] high one cycle, then btn_fall[0] on release after 6 edges.
- Glitch: btn_in[1] high for 3 clocks, then low → btn_out[1] stays 0 and no strobes. Repeat high for 3, low 1, high 3 → still 0.
- Boundary: btn_in[2] high for exactly 4 synchronised cycles, then low → accepted (btn_out[2]=1). Then the fall is accepted 6 edges after release.
- Mid-count reset: btn_in[3] held high; assert rst_n at edge 4 and release → count restarts, and btn_out[3] rises 6 edges after release, not earlier.
- Macro undefined: repeat the clean press → btn_out identical, btn_rise/btn_fall constant 0.
